// File: rtl/i2s_fifo_transmitter.sv
// I2S master transmitter fed from an 8-bit byte FIFO (LSB byte first).
// Ports: clk/rst, enable_i, FIFO read side, I2S pins, underrun pulse/count.
module i2s_fifo_transmitter #(
  parameter int DATA_SIZE = 24,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [7:0]           fifo_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 underrun_o,
  output logic [CNT_WIDTH-1:0] underrun_cnt_o
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int FW    = $clog2(FRAME);
  localparam int DW    = $clog2(CLK_DIV);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [FW-1:0] F_LAST  = FW'(FRAME - 1);
  localparam logic [FW-1:0] F_SLOT  = FW'(SLOT_BITS);
  localparam logic [FW-1:0] F_WS_LO = FW'(SLOT_BITS - 1);
  localparam logic [FW-1:0] F_WS_HI = FW'(FRAME - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPTURE,
    DONE
  } fetch_t;

  logic [DW-1:0]        div_cnt;
  logic                 div_tc;
  logic                 fall;

  logic [FW-1:0]        f;
  logic [FW-1:0]        f_nxt;
  logic                 ws_nxt;
  logic                 slot_start;
  logic [DATA_SIZE-1:0] shreg;
  logic [DATA_SIZE-1:0] load_val;

  fetch_t               state;
  fetch_t               state_nxt;
  logic [IW-1:0]        idx;
  logic [DATA_SIZE-1:0] asm_q;
  logic [DATA_SIZE-1:0] hold;
  logic                 hold_valid;
  logic                 xfer;
  logic                 starve;

  // Bit-clock divider; the falling edge is the only event
  // the frame logic reacts to.
  assign div_tc = enable_i && (div_cnt == DIV_LAST);
  assign fall   = div_tc && i2s_clk;

  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame position of the bit that starts on this fall.
  assign f_nxt = (f == F_LAST) ? '0 : f + 1'b1;
  assign ws_nxt = (f_nxt >= F_WS_LO) && (f_nxt <= F_WS_HI);
  assign slot_start = fall && ((f_nxt == '0) || (f_nxt == F_SLOT));
  assign load_val = hold_valid ? hold : '0;
  assign starve = slot_start && !hold_valid;

  // Zeros shift in behind the sample, so the pad bits
  // after the LSB come out as 0 without extra logic.
  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      f      <= F_LAST;
      i2s_ws <= 1'b0;
      i2s_sd <= 1'b0;
      shreg  <= '0;
    end else if (fall) begin
      f      <= f_nxt;
      i2s_ws <= ws_nxt;
      if (slot_start) begin
        i2s_sd <= load_val[DATA_SIZE-1];
        shreg  <= {load_val[DATA_SIZE-2:0], 1'b0};
      end else begin
        i2s_sd <= shreg[DATA_SIZE-1];
        shreg  <= {shreg[DATA_SIZE-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      underrun_o <= starve;
      if (starve && (underrun_cnt_o != '1)) begin
        underrun_cnt_o <= underrun_cnt_o + 1'b1;
      end
    end
  end

  // Fetch FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM: next state and read strobe.
  // A finished sample may move into hold in the same cycle
  // a slot start empties it.
  always_comb begin
    state_nxt    = state;
    fifo_rd_en_o = 1'b0;
    xfer         = 1'b0;
    unique case (state)
      IDLE, REQ: begin
        if (!fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          state_nxt    = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = (idx == IDX_LAST) ? DONE : REQ;
      end
      DONE: begin
        if (!hold_valid || slot_start) begin
          xfer      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      fifo_rd_en_o = 1'b0;
    end
  end

  // Byte assembly and the one-sample hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      asm_q      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (state == CAPTURE) begin
        for (int b = 0; b < BYTES; b++) begin
          if (idx == IW'(b)) begin
            asm_q[8*b +: 8] <= fifo_data_i;
          end
        end
        if (idx != IDX_LAST) begin
          idx <= idx + 1'b1;
        end
      end
      if (xfer) begin
        hold       <= asm_q;
        idx        <= '0;
        hold_valid <= 1'b1;
      end else if (slot_start) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_fifo_transmitter.sv
// Directed bench for i2s_fifo_transmitter: FIFO model, I2S receiver
// monitor, table of one-frame vectors plus multi-cycle corner cases.
module tb_i2s_fifo_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en2 = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       rd_en, bclk, ws, sd, ur;
  logic [15:0] ur_cnt;
  logic       rd_en2, bclk2, ws2, sd2, ur2o;
  logic [3:0] ur_cnt2;

  i2s_fifo_transmitter dut (
    .clk(clk), .rst(rst), .enable_i(en),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd_en), .i2s_clk(bclk), .i2s_ws(ws),
    .i2s_sd(sd), .underrun_o(ur), .underrun_cnt_o(ur_cnt)
  );

  i2s_fifo_transmitter #(.CLK_DIV(2), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .enable_i(en2),
    .fifo_empty_i(1'b1), .fifo_data_i(8'h00),
    .fifo_rd_en_o(rd_en2), .i2s_clk(bclk2), .i2s_ws(ws2),
    .i2s_sd(sd2), .underrun_o(ur2o), .underrun_cnt_o(ur_cnt2)
  );

  // FIFO model: data appears the cycle after a read strobe.
  logic [7:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      if (wr_ptr == rd_ptr) begin
        rd_bad <= rd_bad + 1;
      end else begin
        fifo_data <= fmem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // I2S receiver model: tracks frame position from BCLK falls,
  // samples SD/WS at BCLK rises, collects completed slots.
  int f_tb = 63;
  bit started = 0;
  bit prev_clk = 0;
  int cyc = 0;
  int last_rise = -1;
  int period = 0;
  int ws_bad = 0;
  int ur2_n = 0;
  logic [31:0] lw, rw;
  logic [32:0] slots[$];
  int ur_f[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst || !en) begin
      f_tb = 63;
      started = 0;
      prev_clk = 0;
      last_rise = -1;
    end else begin
      if (prev_clk && !bclk) begin
        f_tb = (f_tb == 63) ? 0 : f_tb + 1;
        if (f_tb == 0) started = 1;
      end
      if (!prev_clk && bclk) begin
        if (last_rise >= 0) period = cyc - last_rise;
        last_rise = cyc;
        if (started) begin
          if (ws !== (f_tb >= 31 && f_tb <= 62)) ws_bad++;
          if (f_tb < 32) lw[31-f_tb] = sd;
          else rw[63-f_tb] = sd;
          if (f_tb == 31) slots.push_back({1'b0, lw});
          if (f_tb == 63) slots.push_back({1'b1, rw});
        end
      end
      if (ur) ur_f.push_back(f_tb);
      prev_clk = bclk;
    end
  end

  always @(negedge clk) begin
    if (ur2o) ur2_n++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] slot_at(input int i);
    return (slots.size() > i) ? slots[i] : '1;
  endfunction

  function automatic int qf(input int i);
    return (ur_f.size() > i) ? ur_f[i] : -1;
  endfunction

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    en2 = 1'b0;
    repeat (2) @(negedge clk);
    wr_ptr = rd_ptr;
    slots.delete();
    ur_f.delete();
    rst = 1'b0;
  endtask

  task automatic wait_slots(input int n, input int lim, input string nm);
    int k = 0;
    while (slots.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(slots.size() >= n), 64'(1));
  endtask

  typedef struct packed {
    logic [47:0] bytes;
    int          nb;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    int          exp_ur;
  } row_t;

  row_t rows [4];
  int base;
  int base2;
  int k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rows[0] = '{48'hAABBCC_123456, 6, 24'h123456, 24'hAABBCC, 0};
    rows[1] = '{48'h0, 0, 24'h000000, 24'h000000, 2};
    rows[2] = '{48'h000000_030201, 3, 24'h030201, 24'h000000, 1};
    rows[3] = '{48'h800000_FFFFFF, 6, 24'hFFFFFF, 24'h800000, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_pins", 64'({bclk, ws, sd, rd_en, ur}), 64'(0));
    chk("reset_cnt", 64'(ur_cnt), 64'(0));
    rst = 1'b0;

    // One-frame vectors.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      base = rd_cnt;
      for (int i = 0; i < rows[r].nb; i++) push(rows[r].bytes[8*i +: 8]);
      repeat (30) @(negedge clk);
      en = 1'b1;
      wait_slots(2, 9000, "row_slots_seen");
      chk("row_left", 64'(slot_at(0)), 64'({1'b0, rows[r].exp_l, 8'h00}));
      chk("row_right", 64'(slot_at(1)), 64'({1'b1, rows[r].exp_r, 8'h00}));
      chk("row_underruns", 64'(ur_cnt), 64'(rows[r].exp_ur));
      chk("row_ws_timing", 64'(ws_bad), 64'(0));
      chk("row_bclk_period", 64'(period), 64'(64));
      chk("row_reads", 64'(rd_cnt - base), 64'(rows[r].nb));
      en = 1'b0;
    end

    // Empty FIFO for two frames.
    do_reset();
    base = rd_cnt;
    en = 1'b1;
    wait_slots(4, 9000, "empty_slots_seen");
    chk("empty_cnt", 64'(ur_cnt), 64'(4));
    chk("empty_pulses", 64'(ur_f.size()), 64'(4));
    chk("empty_pos0", 64'(qf(0)), 64'(0));
    chk("empty_pos1", 64'(qf(1)), 64'(32));
    chk("empty_pos2", 64'(qf(2)), 64'(0));
    chk("empty_pos3", 64'(qf(3)), 64'(32));
    chk("empty_sd", 64'({slot_at(0)[31:0], slot_at(1)[31:0]} |
                        {slot_at(2)[31:0], slot_at(3)[31:0]}), 64'(0));
    chk("empty_reads", 64'(rd_cnt - base), 64'(0));

    // Stall in the middle of a sample.
    do_reset();
    base = rd_cnt;
    push(8'h11);
    repeat (500) @(negedge clk);
    chk("stall_reads", 64'(rd_cnt - base), 64'(1));
    chk("stall_no_empty_rd", 64'(rd_bad), 64'(0));
    push(8'h22);
    push(8'h33);
    repeat (30) @(negedge clk);
    en = 1'b1;
    wait_slots(1, 4500, "stall_slot_seen");
    chk("stall_sample", 64'(slot_at(0)), 64'({1'b0, 24'h332211, 8'h00}));
    chk("stall_reads_all", 64'(rd_cnt - base), 64'(3));

    // Reset discards a partial sample.
    do_reset();
    en = 1'b1;
    k = 0;
    while (ur_f.size() < 2 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("prerst_cnt", 64'(ur_cnt), 64'(2));
    base = rd_cnt;
    push(8'hA1);
    push(8'hA2);
    k = 0;
    while (rd_cnt - base < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("prerst_reads", 64'(rd_cnt - base), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    chk("rst_pins", 64'({bclk, ws, sd, rd_en, ur}), 64'(0));
    chk("rst_cnt", 64'(ur_cnt), 64'(0));
    rst = 1'b0;
    slots.delete();
    ur_f.delete();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    repeat (30) @(negedge clk);
    en = 1'b1;
    wait_slots(1, 4500, "postrst_slot_seen");
    chk("postrst_sample", 64'(slot_at(0)), 64'({1'b0, 24'h030201, 8'h00}));

    // Disable mid right slot, then resume on the left slot.
    do_reset();
    push(8'hEE); push(8'hFF); push(8'hC0);
    push(8'h9B); push(8'h57); push(8'h13);
    push(8'hAC); push(8'h68); push(8'h24);
    repeat (40) @(negedge clk);
    en = 1'b1;
    wait_slots(1, 4500, "dis_slot_seen");
    chk("dis_left", 64'(slot_at(0)), 64'({1'b0, 24'hC0FFEE, 8'h00}));
    k = 0;
    while (f_tb < 40 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("dis_ws_before", 64'(ws), 64'(1));
    en = 1'b0;
    @(negedge clk);
    chk("dis_pins", 64'({bclk, ws, sd}), 64'(0));
    repeat (100) @(negedge clk);
    slots.delete();
    en = 1'b1;
    wait_slots(1, 4500, "reen_slot_seen");
    chk("reen_left", 64'(slot_at(0)), 64'({1'b0, 24'h2468AC, 8'h00}));
    chk("reen_cnt", 64'(ur_cnt), 64'(0));
    en = 1'b0;

    // Saturating counter on the 4-bit instance.
    do_reset();
    base2 = ur2_n;
    en2 = 1'b1;
    k = 0;
    while (ur2_n - base2 < 14 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("sat_cnt14", 64'(ur_cnt2), 64'(14));
    k = 0;
    while (ur2_n - base2 < 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("sat_pulses", 64'(ur2_n - base2), 64'(20));
    chk("sat_cnt15", 64'(ur_cnt2), 64'(15));
    en2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
